counter_ctrl_unit: RTL and testbench
====================================

Name: counter_ctrl_unit

Overview:
- Control unit for the 14-bit 0..9999 up/down counter.
- Converts debounced button levels into counter controls: en, clear, up_down and a periodic tick.
- Runs a STOP/RUN/CLEAR state machine, owns the tick prescaler and optionally auto-stops at the count boundary.
- Sits between the debouncers and the counter; count feedback comes from the counter output.

Parameters:
- SYS_CLK_HZ, 100_000_000, system clock frequency.
- TICK_HZ, 10, tick rate while running. DIV = SYS_CLK_HZ/TICK_HZ, must be >= 2.
- AUTO_STOP, 0, 1 = stop at terminal count instead of wrapping.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- btn_run_stop  in  1  debounced level; a rising edge toggles run/stop.
- btn_clear  in  1  debounced level; a rising edge requests a clear.
- btn_mode  in  1  debounced level; a rising edge toggles count direction.
- count_in  in  14  current counter value (feedback).
- tick  out  1  one-cycle count pulse to the counter.
- en  out  1  counter enable.
- clear  out  1  counter synchronous clear.
- up_down  out  1  0 = up, 1 = down.
- state  out  2  current FSM state: 0 STOP, 1 RUN, 2 CLEAR.

Behaviour:
- One clock, clk. Reset is synchronous and active-high on reset; polarity and synchronicity are fixed.
- Reset values:
  - state = STOP; en = 0, clear = 0, tick = 0, up_down = 0.
  - prescaler = 0.
  - Edge-detect history registers = 1, so a button held through reset produces no edge.
- Edge detection: edge_x = btn_x & ~prev_x; prev_x <= btn_x every cycle.
- Latency: an edge sampled in cycle n takes effect in outputs in cycle n+1.
- Moore outputs: en = (state == RUN); clear = (state == CLEAR).
- STOP state:
  - clear edge -> CLEAR. This has priority over run_stop.
  - else run_stop edge -> RUN.
  - mode edge toggles up_down. This is independent of and concurrent with the above.
- RUN state:
  - run_stop edge -> STOP.
  - clear and mode edges are ignored.
  - Auto-stop: if AUTO_STOP = 1 and a terminal tick occurs -> STOP.
- CLEAR state: lasts exactly one cycle, then -> STOP unconditionally. Any edges during CLEAR are ignored.
- Prescaler:
  - Counts 0..DIV-1 only while state == RUN; width is clog2(DIV).
  - Forced to 0 in STOP and CLEAR, so the first tick comes DIV cycles after entering RUN.
  - Wraps to 0 after DIV-1.
- Internal tick: tick_int = (state == RUN) && (prescaler == DIV-1).
- Terminal condition: term = (up_down == 0 && count_in == 9999) || (up_down == 1 && count_in == 0).
- Tick output:
  - AUTO_STOP = 0: tick = tick_int; the counter wraps itself.
  - AUTO_STOP = 1: tick = tick_int & ~term. On tick_int & term the state goes to STOP next cycle and no pulse is issued, so the count holds at 9999 or 0.
- tick is registered-free (combinational from registered state/prescaler). It is never high outside RUN.
- Reset mid-RUN: next cycle is STOP, prescaler 0, up_down 0; a pending tick is discarded.

Decomposition:
- Shared package:
  - State encoding constants: ST_STOP = 2'd0, ST_RUN = 2'd1, ST_CLEAR = 2'd2.
  - COUNT_MAX = 9999.
  - COUNT_W = 14.
- One sub-module, tick_gen:
  - Parameter DIV.
  - Ports: clk, reset, run (in), tick_int (out).
  - Counter held at 0 while run = 0.
- The FSM, edge detectors and auto-stop gating stay in counter_ctrl_unit.

Test Plan:
All scenarios use SYS_CLK_HZ = 100 and TICK_HZ = 10, so DIV = 10.
1. Reset with btn_run_stop held high -> state 0, en 0, up_down 0, tick 0. Release and no re-press -> remains STOP.
2. run_stop pulse in STOP at cycle n -> en = 1 from n+1; tick at n+10, n+20, ... Second pulse -> en = 0 next cycle, no further ticks; restart gives first tick 10 cycles after entry.
3. clear pulse in STOP -> clear = 1 for exactly one cycle, state 2, then state 0. clear pulse during RUN -> clear stays 0, en stays 1.
4. mode pulse in STOP -> up_down 0 -> 1. mode pulse in RUN -> up_down unchanged.
5. Terminal count, count_in = 9999, up mode, at tick_int:
   - AUTO_STOP = 1 -> tick = 0, state STOP next cycle.
   - AUTO_STOP = 0 -> tick = 1, stays RUN.
   - Down mode with count_in = 0 behaves likewise.
6. clear and run_stop edges in the same cycle in STOP -> CLEAR then STOP, never RUN. Reset asserted mid-RUN at prescaler 9 -> no tick, state STOP, prescaler 0.

Source files
------------

// File: rtl/counter_ctrl_unit_pkg.sv
// Shared constants for the counter control unit: state encoding and count range.
package counter_ctrl_unit_pkg;

  typedef enum logic [1:0] {
    ST_STOP  = 2'd0,
    ST_RUN   = 2'd1,
    ST_CLEAR = 2'd2
  } ctrl_state_t;

  localparam int COUNT_W   = 14;
  localparam int COUNT_MAX = 9999;

endpackage

// File: rtl/counter_ctrl_unit_tick_gen.sv
// Tick prescaler: counts 0..DIV-1 while run is high, parked at 0 otherwise.
module counter_ctrl_unit_tick_gen #(
  parameter int DIV = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  output logic tick_int
);

  localparam int PW = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] LAST = PW'(DIV - 1);

  logic [PW-1:0] presc_q;
  logic [PW-1:0] presc_d;

  // Next prescaler value: wrap after the last count, hold at 0 when not running.
  always_comb begin
    presc_d = '0;
    if (run && (presc_q != LAST)) begin
      presc_d = presc_q + PW'(1);
    end
  end

  // Prescaler register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_d;
    end
  end

  assign tick_int = run && (presc_q == LAST);

endmodule

// File: rtl/counter_ctrl_unit.sv
// Control unit for the 0..9999 up/down counter: button edge detection,
// STOP/RUN/CLEAR sequencing, tick generation and optional auto-stop.
//
//   state    | meaning
//   ST_STOP  | idle, counter held; clear/run edges accepted, mode toggles direction
//   ST_RUN   | counter enabled, ticks issued every DIV cycles
//   ST_CLEAR | one-cycle counter clear, then back to STOP
module counter_ctrl_unit
  import counter_ctrl_unit_pkg::*;
#(
  parameter int SYS_CLK_HZ = 100_000_000,
  parameter int TICK_HZ    = 10,
  parameter int AUTO_STOP  = 0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               btn_run_stop,
  input  logic               btn_clear,
  input  logic               btn_mode,
  input  logic [COUNT_W-1:0] count_in,
  output logic               tick,
  output logic               en,
  output logic               clear,
  output logic               up_down,
  output logic [1:0]         state
);

  localparam int DIV = SYS_CLK_HZ / TICK_HZ;

  ctrl_state_t state_q;
  logic        en_q;
  logic        clear_q;
  logic        up_down_q;
  logic        prev_run_q;
  logic        prev_clear_q;
  logic        prev_mode_q;

  logic edge_run;
  logic edge_clear;
  logic edge_mode;
  logic tick_int;
  logic term;
  logic auto_stop_hit;

  assign edge_run   = btn_run_stop & ~prev_run_q;
  assign edge_clear = btn_clear    & ~prev_clear_q;
  assign edge_mode  = btn_mode     & ~prev_mode_q;

  assign term = (!up_down_q && (count_in == COUNT_W'(COUNT_MAX))) ||
                ( up_down_q && (count_in == '0));

  assign auto_stop_hit = (AUTO_STOP != 0) && tick_int && term;

  counter_ctrl_unit_tick_gen #(
    .DIV (DIV)
  ) u_tick_gen (
    .clk      (clk),
    .reset    (reset),
    .run      (state_q == ST_RUN),
    .tick_int (tick_int)
  );

  // Button history; reset to 1 so a button held through reset gives no edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      prev_run_q   <= 1'b1;
      prev_clear_q <= 1'b1;
      prev_mode_q  <= 1'b1;
    end else begin
      prev_run_q   <= btn_run_stop;
      prev_clear_q <= btn_clear;
      prev_mode_q  <= btn_mode;
    end
  end

  // Control FSM with registered Moore outputs and direction flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_STOP;
      en_q      <= 1'b0;
      clear_q   <= 1'b0;
      up_down_q <= 1'b0;
    end else begin
      case (state_q)
        ST_STOP: begin
          if (edge_clear) begin
            state_q <= ST_CLEAR;
            en_q    <= 1'b0;
            clear_q <= 1'b1;
          end else if (edge_run) begin
            state_q <= ST_RUN;
            en_q    <= 1'b1;
            clear_q <= 1'b0;
          end
          if (edge_mode) begin
            up_down_q <= ~up_down_q;
          end
        end
        ST_RUN: begin
          if (edge_run || auto_stop_hit) begin
            state_q <= ST_STOP;
            en_q    <= 1'b0;
            clear_q <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_STOP;
          en_q    <= 1'b0;
          clear_q <= 1'b0;
        end
      endcase
    end
  end

  // In auto-stop mode the terminal tick is swallowed so the count holds.
  assign tick    = tick_int & ~auto_stop_hit;
  assign en      = en_q;
  assign clear   = clear_q;
  assign up_down = up_down_q;
  assign state   = state_q;

endmodule

// File: tb/tb_counter_ctrl_unit.sv
// Bench for counter_ctrl_unit: two instances (wrap and auto-stop) driven by the
// same random button/count stimulus, each compared against a cycle model.
module tb_counter_ctrl_unit;

  localparam int DIV    = 10;
  localparam int NCYC   = 4000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        btn_run_stop = 1'b1;
  logic        btn_clear = 1'b0;
  logic        btn_mode = 1'b0;
  logic [13:0] count_in = '0;

  logic       tick_o  [2];
  logic       en_o    [2];
  logic       clear_o [2];
  logic       ud_o    [2];
  logic [1:0] state_o [2];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  counter_ctrl_unit #(.SYS_CLK_HZ(100), .TICK_HZ(10), .AUTO_STOP(0)) u_dut_wrap (
    .clk(clk), .reset(reset), .btn_run_stop(btn_run_stop), .btn_clear(btn_clear),
    .btn_mode(btn_mode), .count_in(count_in), .tick(tick_o[0]), .en(en_o[0]),
    .clear(clear_o[0]), .up_down(ud_o[0]), .state(state_o[0])
  );

  counter_ctrl_unit #(.SYS_CLK_HZ(100), .TICK_HZ(10), .AUTO_STOP(1)) u_dut_auto (
    .clk(clk), .reset(reset), .btn_run_stop(btn_run_stop), .btn_clear(btn_clear),
    .btn_mode(btn_mode), .count_in(count_in), .tick(tick_o[1]), .en(en_o[1]),
    .clear(clear_o[1]), .up_down(ud_o[1]), .state(state_o[1])
  );

  // Reference model: mode name, direction, and cycles spent in RUN since entry.
  int m_st  [2];   // 0 stop, 1 run, 2 clear
  int m_ud  [2];
  int m_cnt [2];
  bit p_rs, p_cl, p_md;
  bit valid = 1'b0;

  task automatic check_val(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  function automatic bit m_term(input int i);
    return (m_ud[i] == 0 && count_in == 14'd9999) || (m_ud[i] == 1 && count_in == 14'd0);
  endfunction

  function automatic bit m_tick_int(input int i);
    return (m_st[i] == 1) && ((m_cnt[i] % DIV) == DIV - 1);
  endfunction

  initial begin
    bit er, ec, em, ti, tm, exp_tick;
    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(negedge clk);
      if (cyc < 3) begin
        reset = 1'b1;
        btn_run_stop = 1'b1;
      end else if (cyc < 8) begin
        reset = 1'b0;
        btn_run_stop = 1'b1;
      end else begin
        reset = ($urandom_range(0, 299) == 0) ||
                (m_tick_int(0) && ($urandom_range(0, 7) == 0));
        if ($urandom_range(0, 39) == 0) btn_run_stop = ~btn_run_stop;
        if ($urandom_range(0, 29) == 0) btn_clear = ~btn_clear;
        if ($urandom_range(0, 19) == 0) btn_mode = ~btn_mode;
        if ((cyc % 500) == 9) begin
          btn_run_stop = 1'b0;
          btn_clear = 1'b0;
        end else if ((cyc % 500) == 10) begin
          btn_run_stop = 1'b1;
          btn_clear = 1'b1;
        end
        case ($urandom_range(0, 3))
          0:       count_in = 14'd9999;
          1:       count_in = 14'd0;
          default: count_in = 14'($urandom_range(0, 9999));
        endcase
      end

      #1;
      if (valid) begin
        for (int i = 0; i < 2; i++) begin
          exp_tick = m_tick_int(i) && !((i == 1) && m_term(i));
          check_val($sformatf("state%0d", i), 16'(state_o[i]), 16'(m_st[i]));
          check_val($sformatf("en%0d", i),    16'(en_o[i]),    16'(m_st[i] == 1));
          check_val($sformatf("clear%0d", i), 16'(clear_o[i]), 16'(m_st[i] == 2));
          check_val($sformatf("updown%0d", i),16'(ud_o[i]),    16'(m_ud[i]));
          check_val($sformatf("tick%0d", i),  16'(tick_o[i]),  16'(exp_tick));
        end
      end

      @(posedge clk);
      if (reset) begin
        for (int i = 0; i < 2; i++) begin
          m_st[i] = 0;
          m_ud[i] = 0;
          m_cnt[i] = 0;
        end
        p_rs = 1'b1;
        p_cl = 1'b1;
        p_md = 1'b1;
        valid = 1'b1;
      end else if (valid) begin
        er = btn_run_stop && !p_rs;
        ec = btn_clear && !p_cl;
        em = btn_mode && !p_md;
        for (int i = 0; i < 2; i++) begin
          ti = m_tick_int(i);
          tm = m_term(i);
          case (m_st[i])
            0: begin
              if (ec) m_st[i] = 2;
              else if (er) begin
                m_st[i] = 1;
                m_cnt[i] = 0;
              end
              if (em) m_ud[i] = 1 - m_ud[i];
            end
            1: begin
              if (er || ((i == 1) && ti && tm)) m_st[i] = 0;
              else m_cnt[i]++;
            end
            default: m_st[i] = 0;
          endcase
        end
        p_rs = btn_run_stop;
        p_cl = btn_clear;
        p_md = btn_mode;
      end
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
